// File: rtl/sc_stream_decoder_pkg.sv
// Shared definitions for the stochastic datapath blocks: FSM states and the
// width helper used to size popcounts and accumulators.
package sc_stream_decoder_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Ceiling log2; callers pass values >= 2 so the result is never zero.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Stream/result bus of the windowed stochastic decoder; slave side is the
// decoder, master side is whoever drives the lanes and drains results.
interface sc_stream_decoder_if
    import sc_stream_decoder_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned WLOG2 = 8
);
    localparam int unsigned CW = WLOG2 + clog2(N + 1);

    logic          EN;
    logic [N-1:0]  IN;
    logic          START;
    logic          CONT;
    logic          CLR;
    logic [CW-1:0] OUT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          BUSY;
    logic          OVF;

    modport master (
        output EN, IN, START, CONT, CLR, OUT_READY,
        input  OUT, OUT_VALID, BUSY, OVF
    );

    modport slave (
        input  EN, IN, START, CONT, CLR, OUT_READY,
        output OUT, OUT_VALID, BUSY, OVF
    );

endinterface

// File: rtl/sc_popcount.sv
// Combinational ones-count across N stochastic lanes, shared by the
// stochastic blocks that need exact (non-OR) lane combination.
module sc_popcount
    import sc_stream_decoder_pkg::*;
#(
    parameter int unsigned N = 3,
    localparam int unsigned PW = clog2(N + 1)
) (
    input  logic [N-1:0]  IN,
    output logic [PW-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + PW'(IN[i]);
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Windowed stochastic-to-binary decoder: sums lane ones over 2^WLOG2 enabled
// cycles and hands the total out through a valid/ready holding register.
module sc_stream_decoder
    import sc_stream_decoder_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned WLOG2 = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    sc_stream_decoder_if.slave bus
);

    localparam int unsigned PW = clog2(N + 1);
    localparam int unsigned CW = WLOG2 + PW;

    state_t           state;
    logic [WLOG2-1:0] cyc;
    logic [CW-1:0]    acc;
    logic [PW-1:0]    pop;
    logic [CW-1:0]    sum;
    logic             last;
    logic             consume;

    sc_popcount #(.N(N)) u_popcount (
        .IN    (bus.IN),
        .count (pop)
    );

    always_comb begin
        sum     = acc + CW'(pop);
        last    = (cyc == '1);
        consume = bus.OUT_VALID && bus.OUT_READY;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            acc           <= '0;
            cyc           <= '0;
            bus.OUT       <= '0;
            bus.OUT_VALID <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.OVF       <= 1'b0;
        end else if (bus.CLR) begin
            state         <= IDLE;
            acc           <= '0;
            cyc           <= '0;
            bus.OUT_VALID <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.OVF       <= 1'b0;
        end else begin
            if (consume) begin
                bus.OUT_VALID <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        state    <= RUN;
                        bus.BUSY <= 1'b1;
                        acc      <= '0;
                        cyc      <= '0;
                    end
                end
                RUN: begin
                    if (bus.EN) begin
                        if (last) begin
                            // A completion reloads OUT even when it is being consumed
                            // this cycle; only an unread result flags overflow.
                            bus.OUT       <= sum;
                            bus.OUT_VALID <= 1'b1;
                            if (bus.OUT_VALID && !bus.OUT_READY) begin
                                bus.OVF <= 1'b1;
                            end
                            acc <= '0;
                            cyc <= '0;
                            if (!bus.CONT) begin
                                state    <= IDLE;
                                bus.BUSY <= 1'b0;
                            end
                        end else begin
                            acc <= sum;
                            cyc <= cyc + WLOG2'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
Windowed stochastic-to-binary decoder. It counts the ones across N parallel stochastic bitstreams over a window of 2^WLOG2 enabled cycles. The block sits at the output end of the stochastic datapath, downstream of the lane-combining gates. Because it popcounts every lane instead of OR-ing them, coincident ones are preserved, so the result is the exact scaled sum. Results are delivered through a valid/ready holding register.

Parameters:
N, 3, number of input bitstream lanes (>=1)
WLOG2, 8, log2 of window length in enabled cycles (>=1)
CW, WLOG2+clog2(N+1), derived result width (localparam, not overridable)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
EN  in  1  sample enable; when low the window stalls (no count, no cycle advance)
IN  in  N  stochastic bitstream lanes
START  in  1  single-cycle pulse; begins a window when IDLE
CONT  in  1  1 = restart the next window immediately after completion; 0 = return to IDLE
CLR  in  1  synchronous abort/clear
OUT  out  CW  decoded count for the last completed window
OUT_VALID  out  1  OUT holds an unconsumed result
OUT_READY  in  1  consumer accepts OUT when high together with OUT_VALID
BUSY  out  1  high in RUN
OVF  out  1  sticky: a completed result overwrote an unconsumed one

Behaviour:
- Reset (RST_N low, async): state IDLE; acc=0, cyc=0, OUT=0, OUT_VALID=0, BUSY=0, OVF=0. All outputs are registered.
- States: IDLE, RUN.
- IDLE:
  - START=1 -> RUN; acc<=0, cyc<=0.
  - No sampling occurs in IDLE.
- RUN, BUSY=1, each cycle with EN=1:
  - acc<=acc+popcount(IN); cyc<=cyc+1.
- RUN with EN=0: acc and cyc hold.
- Window completion: the cycle where EN=1 and cyc==2^WLOG2-1.
  - OUT<=acc+popcount(IN), OUT_VALID<=1 at the next edge. Latency is 1 cycle after the final sample.
  - cyc wraps to 0 and acc<=0.
  - Then RUN if CONT=1, else IDLE.
  - Back-to-back windows in CONT mode have no dead cycle.
- Max result = N*2^WLOG2, which fits in CW bits. No saturation is needed.
- Handshake: OUT_VALID&&OUT_READY consumes. OUT_VALID drops the next cycle unless a completion happens in the same cycle.
  - OUT is stable while OUT_VALID=1, except on overwrite.
- Completion while OUT_VALID=1 and OUT_READY=0:
  - OUT is overwritten with the new result and OUT_VALID stays 1.
  - OVF<=1, and stays set until CLR or reset.
- Completion in the same cycle as a consume: the new value loads, OUT_VALID stays 1, OVF is unaffected.
- START while RUN is ignored.
- CLR=1 (any state) -> IDLE; acc=0, cyc=0, OUT_VALID=0, OVF=0. OUT keeps its last value.
  - CLR beats START and beats a coincident completion.
- Reset mid-window discards the partial count; nothing is emitted.
- EN is sampled only in RUN. IN is don't-care whenever EN=0 or the state is IDLE.

Decomposition:
- Shared stochastic package holds:
  - state encoding constants (IDLE, RUN)
  - clog2 constant function, used for CW
- Natural sub-module: sc_popcount (parameter N; combinational adder tree, IN[N-1:0] -> count[clog2(N+1)-1:0]). It is reusable by other stochastic blocks.
- Decoder top contains:
  - the FSM
  - the cyc counter (WLOG2 bits)
  - acc (CW bits)
  - the output holding register

Test Plan:
- N=3, WLOG2=4, IN=3'b111, EN=1, START, CONT=0, OUT_READY=1 -> OUT_VALID pulses 1 cycle, 17 cycles after START accepted; OUT=48; BUSY falls; state IDLE.
- IN=3'b001 every cycle, EN toggling 1/0 each cycle -> window takes 32 cycles; OUT=16; acc unchanged on EN=0 cycles.
- CONT=1, OUT_READY=0, IN=3'b011 for two windows -> first OUT=32; second completion overwrites OUT with 32; OVF=1. CLR -> OVF=0, OUT_VALID=0.
- CONT=1, OUT_READY asserted exactly on the second completion cycle -> OUT_VALID stays 1, OVF stays 0.
- CLR at cyc=7 mid-window, then START -> new window counts from 0; the first result reflects only post-restart samples (IN=3'b111 -> 48).
- RST_N pulsed low mid-window, asynchronously between edges -> all outputs 0 immediately; no OUT_VALID until a new START plus 16 enabled cycles.
